seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for NUM_DIGITS common-strobe 7-segment digits with hex font,
//  decimal points, per-digit enable, optional leading-zero blanking and anti-ghost dead time.
//  Sits between the counter/datapath logic and the board display pins; value updates are
//  double-buffered and applied only at frame boundaries, so no digit ever shows torn data.
// PARAMETERS
//  NUM_DIGITS     4      digits driven, legal 1..8; digit NUM_DIGITS-1 is most significant
//  SCAN_DIV       50000  clk cycles per digit slot, >= 2 and > DEAD_CYC
//  DEAD_CYC       2      cycles at start of each slot with all anodes inactive, 0..SCAN_DIV-1
//  SEG_ACTIVE_LOW 1      1: segment/dp pin low = lit; 0: high = lit
//  AN_ACTIVE_LOW  1      1: anode pin low = digit selected; 0: high = selected
//  BLANK_LEADING  1      1: suppress leading zeros; 0: show all enabled digits
// PORTS
//  clk        in   1             system clock, all state on rising edge
//  rst_n      in   1             asynchronous active-low reset
//  load       in   1             1-cycle strobe: capture value/dp/digit_en into pending buffer
//  value      in   4*NUM_DIGITS  nibble i = hex digit i
//  dp         in   NUM_DIGITS    bit i lights decimal point of digit i
//  digit_en   in   NUM_DIGITS    bit i = 0 keeps digit i dark (anode never asserted)
//  seg        out  7             {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//  seg_dp     out  1             decimal point, polarity per SEG_ACTIVE_LOW
//  an         out  NUM_DIGITS    digit selects, polarity per AN_ACTIVE_LOW, one-hot or none
//  frame_done out  1             1-cycle pulse when the scan wraps from last digit to digit 0
// BEHAVIOUR
//  Reset (async, rst_n=0): prescaler cnt=0, digit index idx=0, active value/dp/en=0, pending
//   empty; seg/seg_dp = all unlit, an = all inactive, frame_done=0. Held while rst_n=0.
//  Prescaler: cnt counts 0..SCAN_DIV-1, wraps; tick = (cnt==SCAN_DIV-1).
//  Scan: idx increments on tick, wraps NUM_DIGITS-1 -> 0; boundary = tick && idx==NUM_DIGITS-1.
//  Buffering: load=1 writes pending regs and sets pend flag; later load in same frame
//   overwrites (last wins). On boundary with pend=1: active <= pending, pend <= 0.
//   load coincident with boundary: the newly loaded data goes straight to active, pend=0.
//   Data loaded during a frame is visible from digit 0 of the next frame; never mid-frame.
//  Font (active-high gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F
//   A:77 b:7C C:39 d:5E E:79 F:71; inverted when SEG_ACTIVE_LOW=1.
//  Leading-zero blank (BLANK_LEADING=1): digit i>0 blanked when nibbles i..NUM_DIGITS-1 are
//   all 0 in active value; digit 0 never blanked. Blanked digit: segments unlit, anode still
//   driven, dp still honoured. digit_en=0 digit: anode inactive for whole slot.
//  Dead time: an all inactive while cnt < DEAD_CYC; else an selects idx if en[idx]=1.
//  Outputs registered: seg/seg_dp/an/frame_done reflect cnt/idx of previous cycle (latency 1);
//   frame_done asserted the cycle after boundary, coincident with first dead cycle of digit 0.
//  Frame period = NUM_DIGITS*SCAN_DIV cycles; frame_done period identical, independent of load.
//  Reset mid-frame: outputs go unlit/inactive immediately (async), scan restarts at digit 0.
// TESTING
//  T1 reset: assert rst_n=0 mid-slot -> same cycle an=4'b1111, seg=7'h7F, seg_dp=1;
//     release -> first selected anode is digit 0 after DEAD_CYC cycles.
//  T2 NUM_DIGITS=4,SCAN_DIV=4,DEAD_CYC=1: load 16'h1234, en=4'hF -> from next frame, digit0 slot
//     shows seg=7'h19 ('4') with an=4'b1110 for 3 cycles, an=4'b1111 for 1 dead cycle.
//  T3 font: sweep nibble 0..F on digit 0 -> seg equals ~table value each frame.
//  T4 LZB: value 16'h0050 -> digits 3,2 seg=7'h7F; digit1 '5' (7'h12), digit0 '0' (7'h40);
//     value 16'h0000 -> only digit0 lit '0'; BLANK_LEADING=0 -> all four show '0'.
//  T5 buffering: load mid-frame -> outputs unchanged until boundary; two loads in one frame ->
//     second value shown; load on boundary cycle -> shown in immediately following frame.
//  T6 en=4'b0101, dp=4'b0001 -> an never selects digits 1,3; seg_dp=0 only in digit0 slot;
//     frame_done pulses exactly every 16 cycles.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for NUM_DIGITS 7-segment digits.
// A prescaler steps a digit index once per SCAN_DIV cycles. New display data is
// staged in a pending buffer and only promoted to the active buffer when the
// scan wraps from the last digit back to digit 0, so a frame never shows torn data.
// The first DEAD_CYC cycles of every slot keep all anodes off to avoid ghosting.
//
// Interface contract: `load` is a one-cycle capture strobe with no ready/backpressure.
// Every cycle where load=1 is accepted, and the data goes into the pending buffer.
// A load that lands on the wrap cycle goes straight into the active buffer instead.
// All outputs are registered. They reflect the scan position of the previous cycle.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD_CYC       = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [31:0]      DEAD_U  = 32'(DEAD_CYC);
  localparam logic [6:0]       SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic             DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  // Scan position
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tick;
  logic             boundary;

  // Active (displayed) and pending (staged) buffers
  logic [4*NUM_DIGITS-1:0] act_val_q, pend_val_q;
  logic [NUM_DIGITS-1:0]   act_dp_q, pend_dp_q;
  logic [NUM_DIGITS-1:0]   act_en_q, pend_en_q;
  logic                    pend_q;

  // Registered pin drivers
  logic [6:0]            seg_q, seg_d;
  logic                  seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q;

  // Per-slot decode intermediates
  logic [3:0]            nib_sel;
  logic                  dp_sel;
  logic                  en_sel;
  logic                  blank_sel;
  logic                  in_dead;
  logic                  zacc;
  logic [NUM_DIGITS-1:0] lz;
  logic [NUM_DIGITS-1:0] onehot;
  logic [6:0]            seg_lit;
  logic [NUM_DIGITS-1:0] an_lit;

  // Active-high gfedcba glyph for one hex nibble
  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  assign tick     = (cnt_q == CNT_MAX);
  assign boundary = tick && (idx_q == IDX_MAX);

  // Next prescaler count and digit index
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Decode the current slot into pin levels for the next cycle
  always_comb begin
    nib_sel   = 4'h0;
    dp_sel    = 1'b0;
    en_sel    = 1'b0;
    blank_sel = 1'b0;
    onehot    = '0;
    lz        = '0;
    zacc      = 1'b1;
    // lz[i]: nibbles i..top are all zero in the active value
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zacc  = zacc && (act_val_q[i*4 +: 4] == 4'h0);
      lz[i] = zacc;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_sel   = act_val_q[i*4 +: 4];
        dp_sel    = act_dp_q[i];
        en_sel    = act_en_q[i];
        blank_sel = (i != 0) && lz[i];
        onehot[i] = 1'b1;
      end
    end
    in_dead  = (32'(cnt_q) < DEAD_U);
    seg_lit  = ((BLANK_LEADING != 0) && blank_sel) ? 7'h00 : hex_font(nib_sel);
    an_lit   = (in_dead || !en_sel) ? '0 : onehot;
    seg_d    = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
    seg_dp_d = (SEG_ACTIVE_LOW != 0) ? ~dp_sel : dp_sel;
    an_d     = (AN_ACTIVE_LOW != 0) ? ~an_lit : an_lit;
  end

  // Prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Double buffer: stage loads, promote on frame wrap (last load wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_val_q  <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_en_q  <= '0;
      pend_q     <= 1'b0;
    end else if (load) begin
      if (boundary) begin
        act_val_q <= value;
        act_dp_q  <= dp;
        act_en_q  <= digit_en;
        pend_q    <= 1'b0;
      end else begin
        pend_val_q <= value;
        pend_dp_q  <= dp;
        pend_en_q  <= digit_en;
        pend_q     <= 1'b1;
      end
    end else if (boundary && pend_q) begin
      act_val_q <= pend_val_q;
      act_dp_q  <= pend_dp_q;
      act_en_q  <= pend_en_q;
      pend_q    <= 1'b0;
    end
  end

  // Output pin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= SEG_OFF;
      seg_dp_q     <= DP_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
    end
  end

  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with 4 digits, SCAN_DIV=4 and DEAD_CYC=1.
// Two instances share the inputs: dut_a blanks leading zeros and dut_b does not.
// The reference model works from absolute time since reset.
// It derives the slot as t/SCAN_DIV mod digits and the in-slot cycle as t mod SCAN_DIV.
// It swaps display data at frame starts.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int DEAD  = 1;
  localparam int FRAME = ND * SD;
  localparam int W     = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp = '0;
  logic [3:0]    digit_en = '0;
  logic [6:0]    seg_a, seg_b;
  logic          seg_dp_a, seg_dp_b;
  logic [3:0]    an_a, an_b;
  logic          fd_a, fd_b;

  // Scoreboard
  logic [W-1:0]  exp_q[$];
  int            total = 0;
  int            bad = 0;
  bit            running = 1'b0;

  // Reference model state
  int            t = 0;
  logic [15:0]   m_val, p_val;
  logic [3:0]    m_dp, p_dp, m_en, p_en;
  bit            p_flag;
  logic [6:0]    font_tab [16];

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DEAD),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp(dp),
    .digit_en(digit_en), .seg(seg_a), .seg_dp(seg_dp_a), .an(an_a),
    .frame_done(fd_a)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DEAD),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp(dp),
    .digit_en(digit_en), .seg(seg_b), .seg_dp(seg_dp_b), .an(an_b),
    .frame_done(fd_b)
  );

  // Clock
  always #5 clk = ~clk;

  // Direct check used for the asynchronous reset values
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    t      = 0;
    m_val  = '0; m_dp = '0; m_en = '0;
    p_val  = '0; p_dp = '0; p_en = '0;
    p_flag = 1'b0;
  endtask

  // Driver: called at a falling edge. It applies the inputs for the next rising edge
  // and pushes the expected pin state. It then advances the model one cycle.
  task automatic drive_cycle(input bit ld, input logic [15:0] v,
                             input logic [3:0] d, input logic [3:0] e);
    int          idx, c;
    logic [15:0] up;
    logic [6:0]  f, sa, sb;
    logic        dpo, fdo;
    logic [3:0]  a;
    load = ld; value = v; dp = d; digit_en = e;
    idx = (t / SD) % ND;
    c   = t % SD;
    up  = m_val >> (4 * idx);
    f   = font_tab[up[3:0]];
    sb  = ~f;
    sa  = (idx > 0 && up == 16'h0) ? 7'h7F : ~f;
    dpo = ~m_dp[idx];
    a   = (c < DEAD || !m_en[idx]) ? 4'hF : ~(4'b0001 << idx);
    fdo = ((t % FRAME) == FRAME - 1);
    exp_q.push_back({fdo, a, dpo, sa, sb});
    // New data becomes visible at the start of the frame after it was loaded.
    if (ld) begin
      if (fdo) begin
        m_val = v; m_dp = d; m_en = e; p_flag = 1'b0;
      end else begin
        p_val = v; p_dp = d; p_en = e; p_flag = 1'b1;
      end
    end else if (fdo && p_flag) begin
      m_val = p_val; m_dp = p_dp; m_en = p_en; p_flag = 1'b0;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic load_now(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    drive_cycle(1'b1, v, d, e);
  endtask

  // Advance until the next driven cycle is the last cycle of a frame
  task automatic to_boundary();
    while ((t % FRAME) != FRAME - 1) idle(1);
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_an_a"},  32'(an_a), 32'h0000_000F);
    chk({tag, "_seg_a"}, 32'(seg_a), 32'h0000_007F);
    chk({tag, "_dp_a"},  32'(seg_dp_a), 32'h1);
    chk({tag, "_fd_a"},  32'(fd_a), 32'h0);
    chk({tag, "_seg_b"}, 32'(seg_b), 32'h0000_007F);
    chk({tag, "_an_b"},  32'(an_b), 32'h0000_000F);
  endtask

  // Assert reset asynchronously mid-slot, hold it, then release it on a falling edge
  task automatic do_reset_mid();
    load    = 1'b0;
    running = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_pins("rst_async");
    repeat (3) @(negedge clk);
    check_reset_pins("rst_held");
    rst_n = 1'b1;
    model_reset();
    running = 1'b1;
  endtask

  // Monitor: outputs are presented every cycle, so compare one entry per rising edge
  always @(posedge clk) begin
    logic [W-1:0] e, g;
    #1;
    if (running) begin
      total++;
      g = {fd_a, an_a, seg_dp_a, seg_a, seg_b};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scan_no_expected got=%h", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e || an_b !== an_a || seg_dp_b !== seg_dp_a || fd_b !== fd_a) begin
          bad++;
          $display("FAIL scan_out t=%0t got fd=%b an=%b dp=%b seg_a=%h seg_b=%h exp fd=%b an=%b dp=%b seg_a=%h seg_b=%h (b: an=%b dp=%b fd=%b)",
                   $time, g[19], g[18:15], g[14], g[13:7], g[6:0],
                   e[19], e[18:15], e[14], e[13:7], e[6:0], an_b, seg_dp_b, fd_b);
        end
      end
    end
  end

  initial begin
    font_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();

    // Power-on reset
    repeat (2) @(negedge clk);
    check_reset_pins("rst_init");
    rst_n = 1'b1;
    running = 1'b1;

    // Digit readout of 1234 with all digits enabled
    idle(3);
    load_now(16'h1234, 4'h0, 4'hF);
    idle(32);

    // Font sweep on digit 0
    for (int n = 0; n < 16; n++) begin
      load_now({12'h000, 4'(n)}, 4'h0, 4'h1);
      idle(17 + $urandom_range(0, 3));
    end

    // Leading-zero blanking
    load_now(16'h0050, 4'h0, 4'hF);
    idle(32);
    load_now(16'h0000, 4'h0, 4'hF);
    idle(32);
    load_now(16'h0300, 4'h4, 4'hF);
    idle(32);

    // Buffering: two loads in one frame, then a load on the wrap cycle
    to_boundary();
    idle(4);
    load_now(16'hABCD, 4'h0, 4'hF);
    idle(3);
    load_now(16'h9876, 4'h8, 4'hF);
    idle(20);
    to_boundary();
    load_now(16'hE0F1, 4'h2, 4'hF);
    idle(20);

    // Partial enable with a single decimal point
    load_now(16'h8421, 4'b0001, 4'b0101);
    idle(48);

    // Randomized traffic
    repeat (400) begin
      drive_cycle($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom), 4'($urandom));
    end

    // Mid-frame reset, then scanning restarts from digit 0
    idle(5);
    do_reset_mid();
    load_now(16'h00C0, 4'h2, 4'hF);
    idle(40);

    load = 1'b0;
    running = 1'b0;
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
